// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC register, IF/ID pipeline register and RV32 subset decode.
// Optional decode-stage static prediction (jal, backward branches) under `STATIC_PREDICT_EN.
module fetch_decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int CONTROL_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [DATA_WIDTH-1:0]    redirect_pc,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     id_valid,
    output logic [DATA_WIDTH-1:0]    id_pc,
    output logic [31:0]              id_instr,
    output logic [DATA_WIDTH-1:0]    id_imm,
    output logic                     id_reg_write,
    output logic                     id_mem_write,
    output logic                     id_alu_src,
    output logic                     id_branch,
    output logic                     id_jump,
    output logic [CONTROL_WIDTH-1:0] id_alu_ctrl,
    output logic [CONTROL_WIDTH-1:0] id_result_src,
    output logic                     id_illegal,
    output logic                     id_pred_taken
);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [6:0]  OP_R    = 7'b0110011;
    localparam logic [6:0]  OP_I    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD = 7'b0000011;
    localparam logic [6:0]  OP_ST   = 7'b0100011;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [6:0]  OP_LUI  = 7'b0110111;

    logic [DATA_WIDTH-1:0] pc_q, pc_d, id_pc_q, id_pc_d;
    logic [31:0]           id_instr_q, id_instr_d;
    logic                  id_valid_q, id_valid_d;
    logic [31:0]           inst, imm32;
    logic [6:0]            opcode;
    logic [2:0]            funct3, alu3, res3;
    logic                  is_r, is_i, is_load, is_st, is_br, is_jal, is_jalr, is_lui;
    logic                  legal, live, pred;

    assign inst    = id_instr_q;
    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign is_r    = opcode == OP_R;
    assign is_i    = opcode == OP_I;
    assign is_load = opcode == OP_LOAD;
    assign is_st   = opcode == OP_ST;
    assign is_br   = opcode == OP_BR;
    assign is_jal  = opcode == OP_JAL;
    assign is_jalr = opcode == OP_JALR;
    assign is_lui  = opcode == OP_LUI;
    assign legal   = is_r | is_i | is_load | is_st | is_br | is_jal | is_jalr | is_lui;
    assign live    = id_valid_q & legal;

    always_comb begin
        imm32 = (is_i | is_load | is_jalr) ? {{20{inst[31]}}, inst[31:20]} :
                is_st  ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                is_br  ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} :
                is_jal ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} :
                is_lui ? {inst[31:12], 12'b0} : 32'b0;
        alu3  = is_br ? 3'b001 :
                !(is_r | is_i) ? 3'b000 :
                funct3 == 3'b000 ? ((is_r & inst[30]) ? 3'b001 : 3'b000) :
                funct3 == 3'b111 ? 3'b010 :
                funct3 == 3'b110 ? 3'b011 :
                funct3 == 3'b100 ? 3'b100 :
                funct3 == 3'b010 ? 3'b101 : 3'b000;
        res3  = is_load ? 3'b001 : (is_jal | is_jalr) ? 3'b010 : is_lui ? 3'b011 : 3'b000;
    end

    assign id_imm        = DATA_WIDTH'($signed(imm32));
    assign id_reg_write  = live & (is_r | is_i | is_load | is_jal | is_jalr | is_lui);
    assign id_mem_write  = live & is_st;
    assign id_alu_src    = live & (is_i | is_load | is_st | is_jalr | is_lui);
    assign id_branch     = live & is_br;
    assign id_jump       = live & (is_jal | is_jalr);
    assign id_alu_ctrl   = live ? CONTROL_WIDTH'(alu3) : '0;
    assign id_result_src = live ? CONTROL_WIDTH'(res3) : '0;
    assign id_illegal    = id_valid_q & ~legal;

`ifdef STATIC_PREDICT_EN
    // Predict taken for jal and backward branches; depends only on IF/ID state.
    assign pred = live & (is_jal | (is_br & imm32[31]));
`else
    assign pred = 1'b0;
`endif
    assign id_pred_taken = pred;

    always_comb begin
        pc_d       = pc_q + DATA_WIDTH'(4);
        id_valid_d = 1'b1;
        id_pc_d    = pc_q;
        id_instr_d = imem_rdata;
        if (redirect) begin
            pc_d       = redirect_pc & ~DATA_WIDTH'(3);
            id_valid_d = 1'b0;
            id_pc_d    = id_pc_q;
            id_instr_d = NOP;
        end else if (stall) begin
            pc_d       = pc_q;
            id_valid_d = id_valid_q;
            id_pc_d    = id_pc_q;
            id_instr_d = id_instr_q;
        end else if (pred) begin
            pc_d       = id_pc_q + id_imm;
            id_valid_d = 1'b0;
            id_pc_d    = id_pc_q;
            id_instr_d = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP;
        end else begin
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign imem_addr = pc_q[ADDRESS_WIDTH-1:0];
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: decode table plus fetch scoreboard for fetch_decode_stage (default build).
module tb_fetch_decode_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [11:0] ctl;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata, id_pc, id_instr, id_imm;
    logic        id_valid, id_reg_write, id_mem_write, id_alu_src, id_branch, id_jump;
    logic        id_illegal, id_pred_taken;
    logic [2:0]  id_alu_ctrl, id_result_src;

    logic [31:0] mem [256];
    vec_t        vecs [16];
    fetch_t      sb [$];
    int          checks = 0, failures = 0;
    logic [31:0] exp_pc, exp_idpc, exp_instr;
    logic        exp_valid;

    fetch_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .id_imm(id_imm), .id_reg_write(id_reg_write),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_branch(id_branch),
        .id_jump(id_jump), .id_alu_ctrl(id_alu_ctrl), .id_result_src(id_result_src),
        .id_illegal(id_illegal), .id_pred_taken(id_pred_taken)
    );

    assign imem_rdata = mem[imem_addr >> 2];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the reference model, compare after the edge.
    task automatic step(input logic r_n, input logic st, input logic rd, input logic [31:0] rpc);
        fetch_t item;
        logic   fetched;
        rst_n = r_n; stall = st; redirect = rd; redirect_pc = rpc;
        fetched = 1'b0;
        if (r_n && !rd && !st) begin
            sb.push_back('{pc: exp_pc, instr: mem[exp_pc[7:2]]});
            fetched = 1'b1;
        end
        if (!r_n) begin
            exp_pc = '0; exp_valid = 1'b0; exp_idpc = '0; exp_instr = NOP;
        end else if (rd) begin
            exp_pc = rpc & ~32'd3; exp_valid = 1'b0; exp_instr = NOP;
        end else if (!st) begin
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        if (fetched) begin
            item = sb.pop_front();
            exp_valid = 1'b1; exp_idpc = item.pc; exp_instr = item.instr;
        end
        check("imem_addr", {24'b0, imem_addr}, {24'b0, exp_pc[7:0]});
        check("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
        check("id_instr", id_instr, exp_instr);
        check("id_pred_taken", {31'b0, id_pred_taken}, 32'b0);
        if (exp_valid) begin
            check("id_pc", id_pc, exp_idpc);
            if (exp_idpc < 32'd64) begin
                check("id_imm", id_imm, vecs[exp_idpc[5:2]].imm);
                check("id_ctl", {20'b0, id_reg_write, id_mem_write, id_alu_src, id_branch, id_jump,
                      id_alu_ctrl, id_result_src, id_illegal}, {20'b0, vecs[exp_idpc[5:2]].ctl});
            end
        end else begin
            check("bubble_ctl", {27'b0, id_reg_write, id_mem_write, id_branch, id_jump, id_illegal}, 32'b0);
        end
    endtask

    initial begin
        // ctl = {reg_write, mem_write, alu_src, branch, jump, alu_ctrl, result_src, illegal}
        vecs[0]  = '{32'h00100093, 32'h00000001, 12'b1_0_1_0_0_000_000_0};
        vecs[1]  = '{32'hFFF00113, 32'hFFFFFFFF, 12'b1_0_1_0_0_000_000_0};
        vecs[2]  = '{32'h00500193, 32'h00000005, 12'b1_0_1_0_0_000_000_0};
        vecs[3]  = '{32'h7FF00213, 32'h000007FF, 12'b1_0_1_0_0_000_000_0};
        vecs[4]  = '{32'h402082B3, 32'h00000000, 12'b1_0_0_0_0_001_000_0};
        vecs[5]  = '{32'h0020F333, 32'h00000000, 12'b1_0_0_0_0_010_000_0};
        vecs[6]  = '{32'hFF80A383, 32'hFFFFFFF8, 12'b1_0_1_0_0_000_001_0};
        vecs[7]  = '{32'h0020A623, 32'h0000000C, 12'b0_1_1_0_0_000_000_0};
        vecs[8]  = '{32'hFE000EE3, 32'hFFFFFFFC, 12'b0_0_0_1_0_001_000_0};
        vecs[9]  = '{32'h010000EF, 32'h00000010, 12'b1_0_0_0_1_000_010_0};
        vecs[10] = '{32'h00408067, 32'h00000004, 12'b1_0_1_0_1_000_010_0};
        vecs[11] = '{32'h800002B7, 32'h80000000, 12'b1_0_1_0_0_000_011_0};
        vecs[12] = '{32'h0000007F, 32'h00000000, 12'b0_0_0_0_0_000_000_1};
        vecs[13] = '{32'hFFF0C093, 32'hFFFFFFFF, 12'b1_0_1_0_0_100_000_0};
        vecs[14] = '{32'h0020A1B3, 32'h00000000, 12'b1_0_0_0_0_101_000_0};
        vecs[15] = '{32'hFF9FF06F, 32'hFFFFFFF8, 12'b1_0_0_0_1_000_010_0};
        for (int i = 0; i < 256; i++) mem[i] = (i < 16) ? vecs[i].instr : NOP;
        exp_pc = '0; exp_valid = 1'b0; exp_idpc = '0; exp_instr = NOP;

        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("reset_id_pc", id_pc, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_stall_id_pc", id_pc, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            check("stall_addr", {24'b0, imem_addr}, 32'hC);
        end
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("seq_end_id_pc", id_pc, 32'h40);

        step(1'b1, 1'b1, 1'b1, 32'h43);
        check("redir_stall_addr", {24'b0, imem_addr}, 32'h40);
        check("redir_stall_valid", {31'b0, id_valid}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("redir_target_pc", id_pc, 32'h40);

        step(1'b1, 1'b0, 1'b1, 32'h31);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("illegal_valid", {31'b0, id_illegal}, 32'h1);
        step(1'b1, 1'b0, 1'b1, 32'h20);
        check("illegal_flushed", {31'b0, id_illegal}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("beq_branch", {31'b0, id_branch}, 32'h1);

        step(1'b0, 1'b1, 1'b1, 32'h80);
        check("rst_mid_redir_addr", {24'b0, imem_addr}, 32'h0);
        check("rst_mid_redir_valid", {31'b0, id_valid}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("post_rst_pc", id_pc, 32'h0);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
